// File: rtl/d_hazard_branch_pkg.sv
// Shared decode constants, scoreboard entry layout and hazard helpers for the
// decode-stage hazard/branch unit and its instruction classifier.
package d_hazard_branch_pkg;

   // Scoreboard entry geometry
   localparam int REG_W  = 5;
   localparam int TNEW_W = 2;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   // SPECIAL function codes
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;

   // Link register written by jal
   localparam logic [REG_W-1:0] RA_REG = 5'd31;

   // Instruction classes recognised in decode
   typedef enum logic [3:0] {
      K_NOP  = 4'd0,
      K_ADDU = 4'd1,
      K_SUBU = 4'd2,
      K_ORI  = 4'd3,
      K_LUI  = 4'd4,
      K_LW   = 4'd5,
      K_SW   = 4'd6,
      K_BEQ  = 4'd7,
      K_J    = 4'd8,
      K_JAL  = 4'd9,
      K_JR   = 4'd10
   } instr_kind_e;

   // Fetch redirect selector
   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_BEQ = 2'b01,
      PC_J   = 2'b10,
      PC_JR  = 2'b11
   } pcsrc_e;

   // One in-flight producer: destination register and cycles until its result exists
   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [TNEW_W-1:0] tnew;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '{dst: 5'd0, tnew: 2'd0};

   // Age a producer by one stage; tnew never goes below zero
   function automatic logic [TNEW_W-1:0] tnew_decay(input logic [TNEW_W-1:0] tnew);
      logic [TNEW_W-1:0] result;
      if (tnew == 2'd0) begin
         result = 2'd0;
      end else begin
         result = tnew - 2'd1;
      end
      return result;
   endfunction

   // True when a used source operand would read a value this producer has not made yet
   function automatic logic sb_hit(input logic             used,
                                   input logic [REG_W-1:0]  idx,
                                   input logic [TNEW_W-1:0] tuse,
                                   input sb_entry_t         ent);
      return used && (idx != 5'd0) && (idx == ent.dst) && (ent.tnew > tuse);
   endfunction

endpackage

// File: rtl/d_hazard_branch_if.sv
// Decode <-> fetch redirect/stall bundle, plus the scoreboard destinations
// exported for forwarding selection.
interface d_hazard_branch_if;
   import d_hazard_branch_pkg::*;

   logic [31:0]      D_instr;
   logic [31:0]      D_PC;
   logic [31:0]      D_rs_data;
   logic [31:0]      D_rt_data;
   logic [31:0]      next_pc;
   logic [1:0]       PCSrc;
   logic             stall;
   logic             E_clr;
   logic [REG_W-1:0] E_dst;
   logic [REG_W-1:0] M_dst;

   // Pipeline side: presents the IF/ID contents, consumes the redirect
   modport master (
      output D_instr, D_PC, D_rs_data, D_rt_data,
      input  next_pc, PCSrc, stall, E_clr, E_dst, M_dst
   );

   // Hazard/branch unit side
   modport slave (
      input  D_instr, D_PC, D_rs_data, D_rt_data,
      output next_pc, PCSrc, stall, E_clr, E_dst, M_dst
   );

endinterface

// File: rtl/d_hazard_branch_instr_class.sv
// Combinational classifier: from one instruction word produce its class,
// destination register, Tnew when it sits in E, and per-operand Tuse/use flags.
// Written to be instantiated again by the E/M forwarding logic.
module d_instr_class
   import d_hazard_branch_pkg::*;
#(
   parameter logic [TNEW_W-1:0] LOAD_TNEW = 2'd2,
   parameter logic [TNEW_W-1:0] ALU_TNEW  = 2'd1
) (
   input  logic [31:0]       instr,
   output instr_kind_e       kind,
   output logic [REG_W-1:0]  dst,
   output logic [TNEW_W-1:0] tnew_e,
   output logic              use_rs,
   output logic              use_rt,
   output logic [TNEW_W-1:0] tuse_rs,
   output logic [TNEW_W-1:0] tuse_rt
);

   logic [5:0]       op_s;
   logic [5:0]       funct_s;
   logic [REG_W-1:0] rt_s;
   logic [REG_W-1:0] rd_s;
   logic             unused_shamt_s;

   assign op_s           = instr[31:26];
   assign funct_s        = instr[5:0];
   assign rt_s           = instr[20:16];
   assign rd_s           = instr[15:11];
   assign unused_shamt_s = ^instr[10:6];

   // Identify the instruction; anything outside the supported set is a nop
   always_comb begin
      kind = K_NOP;
      case (op_s)
         OP_SPECIAL: begin
            case (funct_s)
               FN_ADDU: kind = K_ADDU;
               FN_SUBU: kind = K_SUBU;
               FN_JR:   kind = K_JR;
               default: kind = K_NOP;
            endcase
         end
         OP_ORI:  kind = K_ORI;
         OP_LUI:  kind = K_LUI;
         OP_LW:   kind = K_LW;
         OP_SW:   kind = K_SW;
         OP_BEQ:  kind = K_BEQ;
         OP_J:    kind = K_J;
         OP_JAL:  kind = K_JAL;
         default: kind = K_NOP;
      endcase
   end

   // Derive destination, result timing and operand demand from the class
   always_comb begin
      dst     = 5'd0;
      tnew_e  = 2'd0;
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      tuse_rs = 2'd0;
      tuse_rt = 2'd0;
      case (kind)
         K_ADDU, K_SUBU: begin
            dst     = rd_s;
            tnew_e  = ALU_TNEW;
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
         end
         K_ORI: begin
            dst     = rt_s;
            tnew_e  = ALU_TNEW;
            use_rs  = 1'b1;
            tuse_rs = 2'd1;
         end
         K_LUI: begin
            dst    = rt_s;
            tnew_e = ALU_TNEW;
         end
         K_LW: begin
            dst     = rt_s;
            tnew_e  = LOAD_TNEW;
            use_rs  = 1'b1;
            tuse_rs = 2'd1;
         end
         K_SW: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd1;
            tuse_rt = 2'd2;
         end
         K_BEQ: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            tuse_rs = 2'd0;
            tuse_rt = 2'd0;
         end
         K_JR: begin
            use_rs  = 1'b1;
            tuse_rs = 2'd0;
         end
         K_JAL: begin
            dst    = RA_REG;
            tnew_e = 2'd0;
         end
         default: begin
            dst     = 5'd0;
            tnew_e  = 2'd0;
         end
      endcase
   end

endmodule

// File: rtl/d_hazard_branch.sv
// Decode-stage hazard and branch unit: decides stalls from a two-entry
// producer scoreboard (E, M) and resolves beq/j/jal/jr redirects for fetch.
// The delay slot is architectural, so fetch is never flushed here.
module d_hazard_branch
   import d_hazard_branch_pkg::*;
#(
   parameter logic [TNEW_W-1:0] LOAD_TNEW = 2'd2,
   parameter logic [TNEW_W-1:0] ALU_TNEW  = 2'd1
) (
   input logic              clk,
   input logic              reset,
   d_hazard_branch_if.slave bus
);

   instr_kind_e       d_kind_s;
   logic [REG_W-1:0]  d_dst_s;
   logic [TNEW_W-1:0] d_tnew_s;
   logic              d_use_rs_s;
   logic              d_use_rt_s;
   logic [TNEW_W-1:0] d_tuse_rs_s;
   logic [TNEW_W-1:0] d_tuse_rt_s;
   logic [REG_W-1:0]  rs_idx_s;
   logic [REG_W-1:0]  rt_idx_s;

   sb_entry_t         e_r;
   sb_entry_t         m_r;

   logic              raw_stall_s;
   logic              stall_s;
   pcsrc_e            raw_pcsrc_s;
   pcsrc_e            pcsrc_s;
   logic [31:0]       seq_pc_s;
   logic [31:0]       br_off_s;
   logic [31:0]       br_pc_s;
   logic [31:0]       j_pc_s;
   logic [31:0]       next_pc_s;

   assign rs_idx_s = bus.D_instr[25:21];
   assign rt_idx_s = bus.D_instr[20:16];

   d_instr_class #(
      .LOAD_TNEW (LOAD_TNEW),
      .ALU_TNEW  (ALU_TNEW)
   ) u_d_class (
      .instr   (bus.D_instr),
      .kind    (d_kind_s),
      .dst     (d_dst_s),
      .tnew_e  (d_tnew_s),
      .use_rs  (d_use_rs_s),
      .use_rt  (d_use_rt_s),
      .tuse_rs (d_tuse_rs_s),
      .tuse_rt (d_tuse_rt_s)
   );

   // Stall when any used operand is still being produced in E or M; reset masks it
   always_comb begin
      raw_stall_s = sb_hit(d_use_rs_s, rs_idx_s, d_tuse_rs_s, e_r)
                  | sb_hit(d_use_rs_s, rs_idx_s, d_tuse_rs_s, m_r)
                  | sb_hit(d_use_rt_s, rt_idx_s, d_tuse_rt_s, e_r)
                  | sb_hit(d_use_rt_s, rt_idx_s, d_tuse_rt_s, m_r);
      if (!reset) begin
         stall_s = 1'b0;
      end else begin
         stall_s = raw_stall_s;
      end
   end

   // Candidate fetch targets; all sums wrap modulo 2^32
   always_comb begin
      seq_pc_s = bus.D_PC + 32'd4;
      br_off_s = {{14{bus.D_instr[15]}}, bus.D_instr[15:0], 2'b00};
      br_pc_s  = seq_pc_s + br_off_s;
      j_pc_s   = {bus.D_PC[31:28], bus.D_instr[25:0], 2'b00};
   end

   // Pick the redirect; stale operands (stall) or reset always fall back to sequential
   always_comb begin
      raw_pcsrc_s = PC_SEQ;
      case (d_kind_s)
         K_BEQ: begin
            if (bus.D_rs_data == bus.D_rt_data) begin
               raw_pcsrc_s = PC_BEQ;
            end else begin
               raw_pcsrc_s = PC_SEQ;
            end
         end
         K_J, K_JAL: raw_pcsrc_s = PC_J;
         K_JR:       raw_pcsrc_s = PC_JR;
         default:    raw_pcsrc_s = PC_SEQ;
      endcase

      if (!reset || raw_stall_s) begin
         pcsrc_s = PC_SEQ;
      end else begin
         pcsrc_s = raw_pcsrc_s;
      end

      case (pcsrc_s)
         PC_BEQ:  next_pc_s = br_pc_s;
         PC_J:    next_pc_s = j_pc_s;
         PC_JR:   next_pc_s = bus.D_rs_data;
         default: next_pc_s = seq_pc_s;
      endcase
   end

   // Advance the scoreboard: E ages into M, D enters E unless a bubble is inserted
   always_ff @(posedge clk) begin
      if (!reset) begin
         e_r <= SB_EMPTY;
         m_r <= SB_EMPTY;
      end else begin
         m_r <= '{dst: e_r.dst, tnew: tnew_decay(e_r.tnew)};
         if (stall_s) begin
            e_r <= SB_EMPTY;
         end else begin
            e_r <= '{dst: d_dst_s, tnew: d_tnew_s};
         end
      end
   end

   assign bus.stall   = stall_s;
   assign bus.E_clr   = stall_s;
   assign bus.PCSrc   = pcsrc_s;
   assign bus.next_pc = next_pc_s;
   assign bus.E_dst   = e_r.dst;
   assign bus.M_dst   = m_r.dst;

endmodule
